uart_rx: RTL and testbench

- Serial receiver for the 8N1 link with the base station. It is the receive counterpart of uart_tx: uart_tx sends drive commands out, and this block takes in acknowledgements and remote commands on a GPIO input.
- Oversamples the line, recovers bytes and buffers them in a small FIFO.
- Presents bytes to the softcore PIO or the drive logic through a valid/ready handshake.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 59 +++++
 rtl/uart_rx.sv | 218 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by uart_rx and uart_tx.
// UART_RX_PARITY_EN adds the PARITY receive state (8E1 framing).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign valid   = (count != '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && valid;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver with FWFT byte FIFO and valid/ready output.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err output.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          uart_in,
    output logic [7:0]                    data_out,
    output logic                          valid,
    input  logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    output logic                          busy
);

    localparam int unsigned DIV   = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SC_W  = $clog2(OVERSAMPLE);
    localparam int unsigned BI_W  = $clog2(UART_DATA_BITS);

    logic rx_meta;
    logic rx_s;
    logic rx_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_in;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    assign tick = (tick_cnt == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    rx_state_t                 state;
    rx_state_t                 state_nxt;
    logic [SC_W-1:0]           sc;
    logic [BI_W-1:0]           bit_idx;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      smp_lo;
    logic                      smp_mid;
    logic                      maj;
    logic                      decide;
    logic                      wrap;
    logic                      push;
    logic                      fe;
`ifdef UART_RX_PARITY_EN
    logic                      par_bad;
    logic                      pe;
`endif

    // Third vote is the live sample taken on the decision tick itself.
    assign maj    = (smp_lo & smp_mid) | (smp_lo & rx_s) | (smp_mid & rx_s);
    assign decide = tick && (sc == SC_W'(OVERSAMPLE/2 + 1));
    assign wrap   = tick && (sc == SC_W'(OVERSAMPLE - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        fe        = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (wrap && (bit_idx == BI_W'(UART_DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    pe = (maj != ^shreg);
                end
                if (wrap) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    if (maj) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad;
`else
                        push = 1'b1;
`endif
                        state_nxt = IDLE;
                    end else begin
                        fe        = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sc is held at zero in IDLE, which gives the required clear on the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sc      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            smp_lo  <= 1'b1;
            smp_mid <= 1'b1;
        end else begin
            if (state == IDLE) begin
                sc <= '0;
            end else if (tick) begin
                sc <= sc + 1'b1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (wrap) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (tick && (sc == SC_W'(OVERSAMPLE/2 - 1))) begin
                smp_lo <= rx_s;
            end
            if (tick && (sc == SC_W'(OVERSAMPLE/2))) begin
                smp_mid <= rx_s;
            end
            if ((state == DATA) && decide) begin
                shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
        end else if (state == IDLE) begin
            par_bad <= 1'b0;
        end else if (pe) begin
            par_bad <= 1'b1;
        end
    end

    assign parity_err = pe;
`endif

    assign frame_err = fe;
    assign busy      = (state != IDLE);

    uart_rx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shreg),
        .pop       (ready),
        .head      (data_out),
        .valid     (valid),
        .count     (fifo_count),
        .dropped   (overrun)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven bench for uart_rx at 432 clk/bit, FIFO_DEPTH=8.
module tb_uart_rx;

    localparam int BIT_CLKS = 432;
    localparam int DIV      = 27;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       uart_in = 1'b1;
    logic       ready   = 1'b0;
    logic [7:0] data_out;
    logic       valid;
    logic [3:0] fifo_count;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ   (50_000_000),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .uart_in    (uart_in),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation happens on the falling edge, away from the active edge.
    byte unsigned rxq[$];
    int   fe_cnt    = 0;
    int   ov_cnt    = 0;
    int   valid_cyc = 0;
    int   busy_fall = 0;
    logic busy_d    = 1'b0;

    always @(negedge clk) begin
        if (valid && ready) rxq.push_back(data_out);
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (valid) valid_cyc++;
        if (busy_d && !busy) busy_fall = cyc;
        busy_d = busy;
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic int rx_at(input int i);
        if (i < rxq.size()) return int'(rxq[i]);
        return -1;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        uart_in = b;
        step(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int start_cyc);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        uart_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, " data_out"},   int'(data_out),   0);
        check({tag, " valid"},      int'(valid),      0);
        check({tag, " fifo_count"}, int'(fifo_count), 0);
        check({tag, " frame_err"},  int'(frame_err),  0);
        check({tag, " overrun"},    int'(overrun),    0);
        check({tag, " busy"},       int'(busy),       0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_push;
        int         exp_fe;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int idx, fe0, ov0, v0, s, s9, f9, delta, fpred;
        byte unsigned exp_seq[9];

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_push: 1, exp_fe: 0};
        vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_push: 1, exp_fe: 0};
        vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_push: 1, exp_fe: 0};
        vecs[3] = '{data: 8'h80, stop_bit: 1'b0, exp_push: 0, exp_fe: 1};

        step(5);
        check_reset_outputs("reset");
        step(1);
        reset_n = 1'b1;
        step(10);

        // Single frames, consumer always ready
        ready = 1'b1;
        foreach (vecs[k]) begin
            idx = rxq.size(); fe0 = fe_cnt; ov0 = ov_cnt; v0 = valid_cyc;
            send_frame(vecs[k].data, vecs[k].stop_bit, s);
            step(60);
            check($sformatf("vec%0d pushes", k), rxq.size() - idx, vecs[k].exp_push);
            if (vecs[k].exp_push != 0)
                check($sformatf("vec%0d byte", k), rx_at(idx), int'(vecs[k].data));
            check($sformatf("vec%0d valid cycles", k), valid_cyc - v0, vecs[k].exp_push);
            check($sformatf("vec%0d frame_err", k), fe_cnt - fe0, vecs[k].exp_fe);
            check($sformatf("vec%0d overrun", k), ov_cnt - ov0, 0);
            check($sformatf("vec%0d count", k), int'(fifo_count), 0);
            check($sformatf("vec%0d busy", k), int'(busy), 0);
        end

        // Start-bit glitch followed by a real frame
        idx = rxq.size(); fe0 = fe_cnt;
        uart_in = 1'b0;
        step(50);
        check("glitch busy rises", int'(busy), 1);
        step(50);
        uart_in = 1'b1;
        step(400);
        check("glitch busy drops", int'(busy), 0);
        check("glitch no push", rxq.size() - idx, 0);
        check("glitch no frame_err", fe_cnt - fe0, 0);
        send_frame(8'h3C, 1'b1, s);
        step(60);
        check("after glitch pushes", rxq.size() - idx, 1);
        check("after glitch byte", rx_at(idx), 'h3C);

        // Bad stop bit, then the line is held low (break)
        idx = rxq.size(); fe0 = fe_cnt;
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i[0]);
        uart_in = 1'b0;
        step(BIT_CLKS + 2000);
        check("break busy held", int'(busy), 1);
        check("break one frame_err", fe_cnt - fe0, 1);
        check("break no push", rxq.size() - idx, 0);
        uart_in = 1'b1;
        step(10);
        check("break busy released", int'(busy), 0);
        check("break still one frame_err", fe_cnt - fe0, 1);

        // Overrun: nine frames into a stalled eight-entry FIFO
        ready = 1'b0;
        idx = rxq.size(); ov0 = ov_cnt;
        for (int b = 1; b <= 8; b++) send_frame(8'(b), 1'b1, s);
        send_frame(8'h09, 1'b1, s9);
        f9 = busy_fall;
        step(20);
        check("overrun count full", int'(fifo_count), 8);
        check("overrun one pulse", ov_cnt - ov0, 1);

        // Full FIFO: pop in exactly the push cycle of a 10th byte.
        // Same start phase against the free-running tick gives the same push timing.
        delta = f9 - s9;
        while (((cyc + 1 - s9) % DIV) != 0) step(1);
        fpred = cyc + 1 + delta;
        fork
            send_frame(8'h0A, 1'b1, s);
            begin
                while (cyc < fpred - 1) begin
                    @(posedge clk);
                    #1;
                end
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
                @(negedge clk);
                check("push+pop count stays 8", int'(fifo_count), 8);
            end
        join
        step(20);
        check("push+pop no overrun", ov_cnt - ov0, 1);
        check("push+pop single pop", rxq.size() - idx, 1);

        ready = 1'b1;
        step(20);
        for (int i = 0; i < 8; i++) exp_seq[i] = 8'(i + 1);
        exp_seq[8] = 8'h0A;
        for (int i = 0; i < 9; i++)
            check($sformatf("drain[%0d]", i), rx_at(idx + i), int'(exp_seq[i]));
        check("drain total", rxq.size() - idx, 9);
        check("drain empty", int'(fifo_count), 0);

        // Reset during bit 4 of 0xF0 with one byte already buffered
        ready = 1'b0;
        send_frame(8'h77, 1'b1, s);
        step(20);
        check("pre-reset count", int'(fifo_count), 1);
        fork
            send_frame(8'hF0, 1'b1, s);
            begin
                step(BIT_CLKS * 5 + 200);
                reset_n = 1'b0;
                check_reset_outputs("midframe reset");
                step(3);
                reset_n = 1'b1;
            end
        join
        ready = 1'b1;
        idx = rxq.size(); fe0 = fe_cnt;
        step(20);
        check("post-reset nothing popped", rxq.size() - idx, 0);
        send_frame(8'h81, 1'b1, s);
        step(60);
        check("post-reset pushes", rxq.size() - idx, 1);
        check("post-reset byte", rx_at(idx), 'h81);
        check("post-reset frame_err", fe_cnt - fe0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
